// File: rtl/systolic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | systolic_pkg: shared types and helpers for the systolic feeder        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package systolic_pkg;

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      CLEAR  = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } feeder_state_e;

   // Cycles needed for the last skewed operand pair to reach the far corner PE
   function automatic int stream_len(input int dim);
      return 3 * dim - 2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_feeder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | systolic_feeder_if: operand load handshake plus systolic array drive  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface systolic_feeder_if #(
   parameter int BITS_AB = 8,
   parameter int BITS_C  = 16,
   parameter int DIM     = 8
);
   logic                          in_valid;
   logic                          in_ready;
   logic [DIM-1:0][BITS_AB-1:0]   in_a;
   logic [DIM-1:0][BITS_AB-1:0]   in_b;
   logic                          sa_en;
   logic [DIM-1:0][BITS_AB-1:0]   sa_a;
   logic [DIM-1:0][BITS_AB-1:0]   sa_b;
   logic                          sa_wren;
   logic [$clog2(DIM)-1:0]        sa_crow;
   logic [DIM-1:0][BITS_C-1:0]    sa_cin;
   logic                          busy;
   logic                          done;

   modport master (
      output in_valid, in_a, in_b,
      input  in_ready, sa_en, sa_a, sa_b, sa_wren, sa_crow, sa_cin, busy, done
   );

   modport slave (
      input  in_valid, in_a, in_b,
      output in_ready, sa_en, sa_a, sa_b, sa_wren, sa_crow, sa_cin, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/systolic_feeder_lane.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | systolic_feeder_lane: one row/column operand buffer with skewed read  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module systolic_feeder_lane #(
   parameter int BITS_AB = 8,
   parameter int DIM     = 8,
   parameter int LANE    = 0,
   parameter int TW      = $clog2(3 * DIM - 1),
   parameter int IW      = $clog2(DIM)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               we,
   input  logic [IW-1:0]      idx,
   input  logic [BITS_AB-1:0] data,
   input  logic               stream,
   input  logic [TW-1:0]      t,
   output logic [BITS_AB-1:0] out
);
   localparam logic [TW-1:0] c_lo = TW'(LANE);

   logic [BITS_AB-1:0] entry_q [DIM];
   logic [BITS_AB-1:0] entry_d [DIM];
   logic [TW-1:0]      w_off;

   always_comb begin
      entry_d = entry_q;
      if (we) begin
         for (int k = 0; k < DIM; k++) begin
            if (idx == IW'(k)) entry_d[k] = data;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DIM; k++) entry_q[k] <= '0;
      end else begin
         entry_q <= entry_d;
      end
   end

   // Lane LANE lags the edge by LANE cycles; outside its DIM-cycle window it feeds zero
   always_comb begin
      w_off = t - c_lo;
      out   = '0;
      if (stream && (t >= c_lo)) begin
         for (int k = 0; k < DIM; k++) begin
            if (w_off == TW'(k)) out = entry_q[k];
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/systolic_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | systolic_feeder: loads A/B beats, clears the array, streams skewed    |
// | operands and pulses done. Rev 1.0                                     |
// +----------------------------------------------------------------------+
module systolic_feeder
   import systolic_pkg::*;
#(
   parameter int BITS_AB = 8,
   parameter int BITS_C  = 16,
   parameter int DIM     = 8
) (
   input  logic               clk,
   input  logic               rst,
   systolic_feeder_if.slave   bus
);
   localparam int              c_stream_len = stream_len(DIM);
   localparam int              IW           = $clog2(DIM);
   localparam int              TW           = $clog2(3 * DIM - 1);
   localparam logic [IW-1:0]   c_last_idx   = IW'(DIM - 1);
   localparam logic [TW-1:0]   c_last_t     = TW'(c_stream_len - 1);

   feeder_state_e state_q, state_d;
   logic [IW-1:0] beat_q, beat_d;
   logic [IW-1:0] row_q, row_d;
   logic [TW-1:0] t_q, t_d;
   logic          w_load;
   logic          w_stream;
   logic          w_xfer;

   logic [DIM-1:0][BITS_AB-1:0] w_sa_a;
   logic [DIM-1:0][BITS_AB-1:0] w_sa_b;

   assign w_load   = (state_q == LOAD);
   assign w_stream = (state_q == STREAM);
   assign w_xfer   = bus.in_valid & w_load;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= LOAD;
         beat_q  <= '0;
         row_q   <= '0;
         t_q     <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         row_q   <= row_d;
         t_q     <= t_d;
      end
   end

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      row_d   = row_q;
      t_d     = t_q;
      case (state_q)
         LOAD: begin
            if (w_xfer) begin
               if (beat_q == c_last_idx) begin
                  state_d = CLEAR;
                  beat_d  = '0;
               end else begin
                  beat_d  = beat_q + 1'b1;
               end
            end
         end
         CLEAR: begin
            if (row_q == c_last_idx) begin
               state_d = STREAM;
               row_d   = '0;
               t_d     = '0;
            end else begin
               row_d   = row_q + 1'b1;
            end
         end
         STREAM: begin
            if (t_q == c_last_t) begin
               state_d = DONE;
               t_d     = '0;
            end else begin
               t_d     = t_q + 1'b1;
            end
         end
         DONE:    state_d = LOAD;
         default: state_d = LOAD;
      endcase
   end

   // Beat k lands at index k of every lane: A lane i holds A[i][*], B lane j holds B[*][j]
   for (genvar g = 0; g < DIM; g++) begin : g_lane
      systolic_feeder_lane #(
         .BITS_AB (BITS_AB),
         .DIM     (DIM),
         .LANE    (g),
         .TW      (TW),
         .IW      (IW)
      ) u_lane_a (
         .clk    (clk),
         .rst    (rst),
         .we     (w_xfer),
         .idx    (beat_q),
         .data   (bus.in_a[g]),
         .stream (w_stream),
         .t      (t_q),
         .out    (w_sa_a[g])
      );

      systolic_feeder_lane #(
         .BITS_AB (BITS_AB),
         .DIM     (DIM),
         .LANE    (g),
         .TW      (TW),
         .IW      (IW)
      ) u_lane_b (
         .clk    (clk),
         .rst    (rst),
         .we     (w_xfer),
         .idx    (beat_q),
         .data   (bus.in_b[g]),
         .stream (w_stream),
         .t      (t_q),
         .out    (w_sa_b[g])
      );
   end

   assign bus.in_ready = w_load;
   assign bus.busy     = ~w_load;
   assign bus.done     = (state_q == DONE);
   assign bus.sa_en    = w_stream;
   assign bus.sa_wren  = (state_q == CLEAR);
   assign bus.sa_crow  = (state_q == CLEAR) ? row_q : '0;
   assign bus.sa_cin   = {(DIM * BITS_C){1'b0}};
   assign bus.sa_a     = w_sa_a;
   assign bus.sa_b     = w_sa_b;
endmodule
`default_nettype wire

// File: tb/tb_systolic_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_systolic_feeder: directed vectors for the feeder with a PE-grid     |
// | product model. Rev 1.0                                                |
// +----------------------------------------------------------------------+
module tb_systolic_feeder;
   localparam int D = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   systolic_feeder_if #(.BITS_AB(8), .BITS_C(16), .DIM(D)) bus ();
   systolic_feeder    #(.BITS_AB(8), .BITS_C(16), .DIM(D)) dut (.clk(clk), .rst(rst), .bus(bus));

   systolic_feeder_if #(.BITS_AB(8), .BITS_C(16), .DIM(2)) bus2 ();
   systolic_feeder    #(.BITS_AB(8), .BITS_C(16), .DIM(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

   typedef struct packed {
      logic [D-1:0][D-1:0][7:0]  a;     // a[i][k]
      logic [D-1:0][D-1:0][7:0]  b;     // b[k][j]
      logic [D-1:0][D-1:0][15:0] c;     // c[i][j]
      logic [1:0]                mode;  // 0 hold valid, 1 toggle, 2 random
   } vec_t;

   vec_t vecs [4];
   int   checks = 0;
   int   errors = 0;

   // Output-stationary PE grid: A flows east, B flows south, C accumulates in place
   logic signed [7:0]  ma [D][D];
   logic signed [7:0]  mb [D][D];
   logic signed [15:0] mc [D][D];

   function automatic logic signed [7:0] a_in(input int i, input int j);
      if (j == 0) return $signed(bus.sa_a[i]);
      return ma[i][j-1];
   endfunction

   function automatic logic signed [7:0] b_in(input int i, input int j);
      if (i == 0) return $signed(bus.sa_b[j]);
      return mb[i-1][j];
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < D; i++)
            for (int j = 0; j < D; j++) begin
               ma[i][j] <= '0;
               mb[i][j] <= '0;
               mc[i][j] <= '0;
            end
      end else begin
         if (bus.sa_wren)
            for (int j = 0; j < D; j++) mc[bus.sa_crow][j] <= $signed(bus.sa_cin[j]);
         if (bus.sa_en)
            for (int i = 0; i < D; i++)
               for (int j = 0; j < D; j++) begin
                  ma[i][j] <= a_in(i, j);
                  mb[i][j] <= b_in(i, j);
                  mc[i][j] <= mc[i][j] + a_in(i, j) * b_in(i, j);
               end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [D-1:0][7:0] exp_a(input int vi, input int t);
      logic [D-1:0][7:0] r;
      r = '0;
      for (int i = 0; i < D; i++)
         if (t - i >= 0 && t - i < D) r[i] = vecs[vi].a[i][t-i];
      return r;
   endfunction

   function automatic logic [D-1:0][7:0] exp_b(input int vi, input int t);
      logic [D-1:0][7:0] r;
      r = '0;
      for (int j = 0; j < D; j++)
         if (t - j >= 0 && t - j < D) r[j] = vecs[vi].b[t-j][j];
      return r;
   endfunction

   // Loads, clears and streams one product; returns at the done cycle, or with rst held on abort
   task automatic run_product(input int vi, input int abort_t, input bit b2b);
      int   k = 0;
      int   cyc = 0;
      int   rdy_cyc = 0;
      int   first_acc = -1;
      logic v, rdy;
      logic [63:0] row;
      while (k < D && cyc < 200) begin
         case (vecs[vi].mode)
            2'd0:    v = 1'b1;
            2'd1:    v = (cyc % 2 == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         bus.in_valid = v;
         for (int i = 0; i < D; i++) bus.in_a[i] = vecs[vi].a[i][k];
         for (int j = 0; j < D; j++) bus.in_b[j] = vecs[vi].b[k][j];
         rdy = bus.in_ready;
         if (rdy) rdy_cyc++;
         if (v && rdy && first_acc < 0) first_acc = cyc;
         step();
         cyc++;
         if (v && rdy) k++;
      end
      bus.in_valid = 1'b0;
      if (k != D) begin
         chk("load_timeout", 64'(k), 64'(D));
         return;
      end
      if (vecs[vi].mode == 2'd0) chk("load_cycles", 64'(rdy_cyc), 64'(D));
      if (b2b) chk("b2b_first_accept", 64'(first_acc), 64'd1);
      chk("ready_drop", {bus.in_ready, bus.busy}, 2'b01);
      for (int r = 0; r < D; r++) begin
         chk("clear_ctl", {bus.sa_wren, bus.sa_crow, bus.sa_en, bus.in_ready, bus.done},
             {1'b1, 2'(r), 3'b000});
         chk("clear_cin", bus.sa_cin, 64'd0);
         step();
      end
      for (int t = 0; t < 3 * D - 2; t++) begin
         chk("stream_ctl", {bus.sa_en, bus.sa_wren, bus.sa_crow, bus.done, bus.busy}, 6'b100001);
         chk("stream_a", bus.sa_a, exp_a(vi, t));
         chk("stream_b", bus.sa_b, exp_b(vi, t));
         if (t == abort_t) begin
            rst = 1'b1;
            #1;
            chk("abort_ctl", {bus.sa_en, bus.busy, bus.sa_wren}, 3'b000);
            chk("abort_sa", {bus.sa_a, bus.sa_b}, 64'd0);
            return;
         end
         step();
      end
      chk("done_ctl", {bus.done, bus.sa_en, bus.sa_wren, bus.busy, bus.in_ready}, 5'b10010);
      chk("done_ab", {bus.sa_a, bus.sa_b}, 64'd0);
      for (int r = 0; r < D; r++) begin
         row = {mc[r][3], mc[r][2], mc[r][1], mc[r][0]};
         chk("c_row", row, vecs[vi].c[r]);
      end
   endtask

   initial begin
      int n_clr, n_str;
      logic seen_done;
      logic [15:0] a_t0, b_t0, a_t1, b_t1;

      for (int i = 0; i < D; i++)
         for (int j = 0; j < D; j++) begin
            vecs[0].a[i][j] = (i == j) ? 8'd1 : 8'd0;
            vecs[0].b[i][j] = 8'(4 * i + j + 1);
            vecs[0].c[i][j] = 16'(4 * i + j + 1);
            vecs[1].a[i][j] = 8'd1;
            vecs[1].b[i][j] = 8'd1;
            vecs[1].c[i][j] = 16'd4;
            vecs[2].a[i][j] = (i == j) ? 8'd2 : 8'd0;
            vecs[2].b[i][j] = 8'(i - j);
            vecs[2].c[i][j] = 16'(2 * (i - j));
            vecs[3].a[i][j] = 8'h80;
            vecs[3].b[i][j] = 8'h80;
            vecs[3].c[i][j] = 16'(4 * 16384);
         end
      vecs[0].mode = 2'd0;
      vecs[1].mode = 2'd1;
      vecs[2].mode = 2'd2;
      vecs[3].mode = 2'd0;

      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus2.in_valid = 1'b0;
      bus2.in_a     = '0;
      bus2.in_b     = '0;

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ctl", {bus.sa_en, bus.sa_wren, bus.done, bus.busy, bus.sa_crow}, 6'd0);
      chk("reset_cin", bus.sa_cin, 64'd0);
      rst = 1'b0;
      step();
      chk("reset_ready", {bus.in_ready, bus.busy, bus.done}, 3'b100);
      chk("reset_sa", {bus.sa_a, bus.sa_b}, 64'd0);

      run_product(0, -1, 1'b0);
      step();
      chk("post_done", {bus.done, bus.in_ready, bus.busy}, 3'b010);
      run_product(1, -1, 1'b0);
      step();
      chk("post_done", {bus.done, bus.in_ready, bus.busy}, 3'b010);
      run_product(2, -1, 1'b0);
      run_product(3, -1, 1'b1);
      step();

      run_product(0, 5, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("abort_release", {bus.in_ready, bus.busy, bus.sa_en}, 3'b100);
      step();
      run_product(2, -1, 1'b0);
      step();

      // DIM=2 instance: A=[[1,2],[3,4]], B=[[5,6],[7,8]]
      bus2.in_valid = 1'b1;
      bus2.in_a = {8'd3, 8'd1};
      bus2.in_b = {8'd6, 8'd5};
      step();
      bus2.in_a = {8'd4, 8'd2};
      bus2.in_b = {8'd8, 8'd7};
      step();
      bus2.in_valid = 1'b0;
      n_clr = 0;
      n_str = 0;
      seen_done = 1'b0;
      a_t0 = '0; b_t0 = '0; a_t1 = '0; b_t1 = '0;
      for (int c = 0; c < 40 && !seen_done; c++) begin
         if (bus2.sa_wren) n_clr++;
         if (bus2.sa_en) begin
            if (n_str == 0) begin a_t0 = bus2.sa_a; b_t0 = bus2.sa_b; end
            if (n_str == 1) begin a_t1 = bus2.sa_a; b_t1 = bus2.sa_b; end
            n_str++;
         end
         if (bus2.done) seen_done = 1'b1;
         else step();
      end
      chk("d2_done_seen", 64'(seen_done), 64'd1);
      chk("d2_clear_len", 64'(n_clr), 64'd2);
      chk("d2_stream_len", 64'(n_str), 64'd4);
      chk("d2_t0", {a_t0, b_t0}, {16'h0001, 16'h0005});
      chk("d2_t1", {a_t1, b_t1}, {16'h0302, 16'h0607});
      step();
      chk("d2_post_done", {bus2.done, bus2.in_ready}, 2'b01);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
